// File: rtl/alu_rs.sv
// alu_rs: reservation station for integer/branch ops. Buffers dispatched
// ops until both operands are known (snooping the ALU and LSB CDB ports),
// then issues at most one ready op per cycle on registered outputs that
// feed the combinational ALU. ROB index 0 means "no tag / operand ready".
module alu_rs #(
    parameter int RS_SIZE   = 16,
    parameter int OPT_W     = 6,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,

    input  logic                 disp_valid,
    input  logic [OPT_W-1:0]     disp_opt,
    input  logic [31:0]          disp_val1,
    input  logic [ROB_IDX_W-1:0] disp_q1,
    input  logic [31:0]          disp_val2,
    input  logic [ROB_IDX_W-1:0] disp_q2,
    input  logic [31:0]          disp_imm,
    input  logic [ROB_IDX_W-1:0] disp_rob_idx,

    input  logic                 cdb_alu_valid,
    input  logic [ROB_IDX_W-1:0] cdb_alu_src,
    input  logic [31:0]          cdb_alu_val,
    input  logic                 cdb_lsb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_lsb_src,
    input  logic [31:0]          cdb_lsb_val,

    output logic                 rs_full,
    output logic                 rs_valid,
    output logic [OPT_W-1:0]     rs_opt,
    output logic [31:0]          rs_val1,
    output logic [31:0]          rs_val2,
    output logic [31:0]          rs_imm,
    output logic [ROB_IDX_W-1:0] rs_rob_idx
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    // Entry storage: busy/count are control state, the rest is payload.
    logic [RS_SIZE-1:0]   busy;
    logic [OPT_W-1:0]     e_opt [RS_SIZE];
    logic [31:0]          e_v1  [RS_SIZE];
    logic [ROB_IDX_W-1:0] e_q1  [RS_SIZE];
    logic [31:0]          e_v2  [RS_SIZE];
    logic [ROB_IDX_W-1:0] e_q2  [RS_SIZE];
    logic [31:0]          e_imm [RS_SIZE];
    logic [ROB_IDX_W-1:0] e_rob [RS_SIZE];
    logic [CNT_W-1:0]     count;

    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 issue;
    logic [IDX_W-1:0]     sel_idx;
    logic                 disp_accept;
    logic [31:0]          d_v1, d_v2;
    logic [ROB_IDX_W-1:0] d_q1, d_q2;

    // A tag only matches a CDB port when it is a real (nonzero) tag.
    function automatic logic alu_hit(input logic [ROB_IDX_W-1:0] q);
        return (q != '0) && cdb_alu_valid && (cdb_alu_src == q);
    endfunction

    function automatic logic lsb_hit(input logic [ROB_IDX_W-1:0] q);
        return (q != '0) && cdb_lsb_valid && (cdb_lsb_src == q);
    endfunction

    assign rs_full     = (count == CNT_W'(RS_SIZE));
    assign disp_accept = disp_valid && !rs_full;

    // Find the lowest free slot and the lowest ready slot (state at cycle start).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        free_found = 1'b0;
        free_idx   = '0;
        issue      = 1'b0;
        sel_idx    = '0;
        // Descending scan so the last hit (lowest index) wins.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy[i] && (e_q1[i] == '0) && (e_q2[i] == '0)) begin
                issue   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Dispatch-time forwarding from a same-cycle CDB broadcast; ALU port first.
    always_comb begin
        d_v1 = disp_val1;
        d_q1 = disp_q1;
        d_v2 = disp_val2;
        d_q2 = disp_q2;
        if (alu_hit(disp_q1)) begin
            d_v1 = cdb_alu_val;
            d_q1 = '0;
        end else if (lsb_hit(disp_q1)) begin
            d_v1 = cdb_lsb_val;
            d_q1 = '0;
        end
        if (alu_hit(disp_q2)) begin
            d_v2 = cdb_alu_val;
            d_q2 = '0;
        end else if (lsb_hit(disp_q2)) begin
            d_v2 = cdb_lsb_val;
            d_q2 = '0;
        end
    end

    // Control state and issue registers: flush on rst/rollback, hold when !rdy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst || rollback) begin
            busy       <= '0;
            count      <= '0;
            rs_valid   <= 1'b0;
            rs_opt     <= '0;
            rs_val1    <= '0;
            rs_val2    <= '0;
            rs_imm     <= '0;
            rs_rob_idx <= '0;
        end else if (rdy) begin
            if (issue) begin
                busy[sel_idx] <= 1'b0;
                rs_valid      <= 1'b1;
                rs_opt        <= e_opt[sel_idx];
                rs_val1       <= e_v1[sel_idx];
                rs_val2       <= e_v2[sel_idx];
                rs_imm        <= e_imm[sel_idx];
                rs_rob_idx    <= e_rob[sel_idx];
            end else begin
                rs_valid   <= 1'b0;
                rs_opt     <= '0;
                rs_val1    <= '0;
                rs_val2    <= '0;
                rs_imm     <= '0;
                rs_rob_idx <= '0;
            end
            // The free slot is never the issuing slot (that one is busy).
            if (disp_accept && free_found) begin
                busy[free_idx] <= 1'b1;
            end
            count <= count + CNT_W'(disp_accept) - CNT_W'(issue);
        end
    end

    // Entry payload: CDB wakeup of busy entries and writing of a dispatched entry.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; busy alone decides whether an entry is live.
        if (!rst && !rollback && rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    if (alu_hit(e_q1[i])) begin
                        e_v1[i] <= cdb_alu_val;
                        e_q1[i] <= '0;
                    end else if (lsb_hit(e_q1[i])) begin
                        e_v1[i] <= cdb_lsb_val;
                        e_q1[i] <= '0;
                    end
                    if (alu_hit(e_q2[i])) begin
                        e_v2[i] <= cdb_alu_val;
                        e_q2[i] <= '0;
                    end else if (lsb_hit(e_q2[i])) begin
                        e_v2[i] <= cdb_lsb_val;
                        e_q2[i] <= '0;
                    end
                end
            end
            if (disp_accept && free_found) begin
                e_opt[free_idx] <= disp_opt;
                e_v1[free_idx]  <= d_v1;
                e_q1[free_idx]  <= d_q1;
                e_v2[free_idx]  <= d_v2;
                e_q2[free_idx]  <= d_q2;
                e_imm[free_idx] <= disp_imm;
                e_rob[free_idx] <= disp_rob_idx;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed checks of the ALU reservation station.
module tb_alu_rs;

    localparam int RS_SIZE   = 16;
    localparam int OPT_W     = 6;
    localparam int ROB_IDX_W = 4;

    localparam logic [OPT_W-1:0] OP_ADDI = 6'd1;
    localparam logic [OPT_W-1:0] OP_ADD  = 6'd2;

    logic                 clk = 1'b0;
    logic                 rst, rdy, rollback;
    logic                 disp_valid;
    logic [OPT_W-1:0]     disp_opt;
    logic [31:0]          disp_val1, disp_val2, disp_imm;
    logic [ROB_IDX_W-1:0] disp_q1, disp_q2, disp_rob_idx;
    logic                 cdb_alu_valid, cdb_lsb_valid;
    logic [ROB_IDX_W-1:0] cdb_alu_src, cdb_lsb_src;
    logic [31:0]          cdb_alu_val, cdb_lsb_val;
    logic                 rs_full, rs_valid;
    logic [OPT_W-1:0]     rs_opt;
    logic [31:0]          rs_val1, rs_val2, rs_imm;
    logic [ROB_IDX_W-1:0] rs_rob_idx;

    int checks = 0;
    int errors = 0;

    alu_rs #(.RS_SIZE(RS_SIZE), .OPT_W(OPT_W), .ROB_IDX_W(ROB_IDX_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .disp_valid(disp_valid), .disp_opt(disp_opt),
        .disp_val1(disp_val1), .disp_q1(disp_q1),
        .disp_val2(disp_val2), .disp_q2(disp_q2),
        .disp_imm(disp_imm), .disp_rob_idx(disp_rob_idx),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_src(cdb_lsb_src), .cdb_lsb_val(cdb_lsb_val),
        .rs_full(rs_full), .rs_valid(rs_valid), .rs_opt(rs_opt),
        .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [OPT_W-1:0] opt, input logic [31:0] v1,
                        input logic [ROB_IDX_W-1:0] q1, input logic [31:0] v2,
                        input logic [ROB_IDX_W-1:0] q2, input logic [31:0] imm,
                        input logic [ROB_IDX_W-1:0] rob);
        disp_valid   = 1'b1;
        disp_opt     = opt;
        disp_val1    = v1;
        disp_q1      = q1;
        disp_val2    = v2;
        disp_q2      = q2;
        disp_imm     = imm;
        disp_rob_idx = rob;
    endtask

    task automatic idle();
        disp_valid    = 1'b0;
        disp_opt      = '0;
        disp_val1     = '0;
        disp_q1       = '0;
        disp_val2     = '0;
        disp_q2       = '0;
        disp_imm      = '0;
        disp_rob_idx  = '0;
        cdb_alu_valid = 1'b0;
        cdb_alu_src   = '0;
        cdb_alu_val   = '0;
        cdb_lsb_valid = 1'b0;
        cdb_lsb_src   = '0;
        cdb_lsb_val   = '0;
    endtask

    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        rollback = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("reset_valid", 32'(rs_valid), 32'd0);
        check("reset_full", 32'(rs_full), 32'd0);
        check("reset_rob", 32'(rs_rob_idx), 32'd0);
        check("reset_count", 32'(dut.count), 32'd0);

        // ADDI, both operands ready: issues after the second edge.
        disp(OP_ADDI, 32'd5, 4'd0, 32'd0, 4'd0, 32'd7, 4'd3);
        tick();
        idle();
        check("addi_not_yet", 32'(rs_valid), 32'd0);
        tick();
        check("addi_valid", 32'(rs_valid), 32'd1);
        check("addi_opt", 32'(rs_opt), 32'(OP_ADDI));
        check("addi_val1", rs_val1, 32'd5);
        check("addi_imm", rs_imm, 32'd7);
        check("addi_rob", 32'(rs_rob_idx), 32'd3);
        tick();
        check("addi_pulse_end", 32'(rs_valid), 32'd0);
        check("addi_count", 32'(dut.count), 32'd0);

        // ADD waiting on tag 4; unrelated tag 5 and a src=0 broadcast wake nothing.
        disp(OP_ADD, 32'd0, 4'd4, 32'd10, 4'd0, 32'd0, 4'd2);
        tick();
        idle();
        cdb_alu_valid = 1'b1; cdb_alu_src = 4'd5; cdb_alu_val = 32'h99;
        tick();
        idle();
        cdb_lsb_valid = 1'b1; cdb_lsb_src = 4'd0; cdb_lsb_val = 32'h55;
        tick();
        idle();
        check("add_wait_valid", 32'(rs_valid), 32'd0);
        check("add_wait_count", 32'(dut.count), 32'd1);
        cdb_alu_valid = 1'b1; cdb_alu_src = 4'd4; cdb_alu_val = 32'h20;
        tick();
        idle();
        check("add_wake_edge", 32'(rs_valid), 32'd0);
        tick();
        check("add_valid", 32'(rs_valid), 32'd1);
        check("add_val1", rs_val1, 32'h20);
        check("add_val2", rs_val2, 32'd10);
        check("add_rob", 32'(rs_rob_idx), 32'd2);
        tick();
        check("add_pulse_end", 32'(rs_valid), 32'd0);

        // Dispatch-time forwarding from the LSB port.
        disp(OP_ADD, 32'd0, 4'd6, 32'd1, 4'd0, 32'd0, 4'd5);
        cdb_lsb_valid = 1'b1; cdb_lsb_src = 4'd6; cdb_lsb_val = 32'hDEAD;
        tick();
        idle();
        tick();
        check("fwd_valid", 32'(rs_valid), 32'd1);
        check("fwd_val1", rs_val1, 32'hDEAD);
        check("fwd_rob", 32'(rs_rob_idx), 32'd5);
        tick();

        // Fill all 16 slots waiting on tag 7; a 17th (ready) dispatch is dropped.
        for (int i = 0; i < RS_SIZE; i++) begin
            disp(OP_ADD, 32'd0, 4'd7, 32'd3, 4'd0, 32'd100 + 32'(i), 4'd1);
            tick();
        end
        idle();
        check("fill_full", 32'(rs_full), 32'd1);
        check("fill_count", 32'(dut.count), 32'd16);
        disp(OP_ADDI, 32'd1, 4'd0, 32'd0, 4'd0, 32'd999, 4'd9);
        tick();
        idle();
        check("drop_full", 32'(rs_full), 32'd1);
        check("drop_count", 32'(dut.count), 32'd16);
        tick();
        check("drop_no_issue", 32'(rs_valid), 32'd0);
        cdb_alu_valid = 1'b1; cdb_alu_src = 4'd7; cdb_alu_val = 32'h77;
        tick();
        idle();
        check("drain_wake_edge", 32'(rs_valid), 32'd0);
        for (int i = 0; i < RS_SIZE; i++) begin
            tick();
            check($sformatf("drain_valid_%0d", i), 32'(rs_valid), 32'd1);
            check($sformatf("drain_imm_%0d", i), rs_imm, 32'd100 + 32'(i));
            check($sformatf("drain_val1_%0d", i), rs_val1, 32'h77);
            if (i == 0) check("drain_full_drop", 32'(rs_full), 32'd0);
        end
        tick();
        check("drain_done_valid", 32'(rs_valid), 32'd0);
        check("drain_done_count", 32'(dut.count), 32'd0);

        // Five entries waiting on tag 8, then rollback with a same-cycle dispatch.
        for (int i = 0; i < 5; i++) begin
            disp(OP_ADD, 32'd0, 4'd8, 32'd0, 4'd0, 32'd200 + 32'(i), 4'd2);
            tick();
        end
        idle();
        check("rb_pre_count", 32'(dut.count), 32'd5);
        rollback = 1'b1;
        disp(OP_ADDI, 32'd4, 4'd0, 32'd0, 4'd0, 32'd444, 4'd4);
        tick();
        rollback = 1'b0;
        idle();
        check("rb_valid", 32'(rs_valid), 32'd0);
        check("rb_count", 32'(dut.count), 32'd0);
        check("rb_full", 32'(rs_full), 32'd0);
        tick();
        check("rb_disp_dropped", 32'(rs_valid), 32'd0);
        cdb_alu_valid = 1'b1; cdb_alu_src = 4'd8; cdb_alu_val = 32'h88;
        tick();
        idle();
        tick();
        check("rb_stale_wake_1", 32'(rs_valid), 32'd0);
        tick();
        check("rb_stale_wake_2", 32'(rs_valid), 32'd0);

        // Two entries made ready, then rdy low for 3 cycles with ignored inputs.
        disp(OP_ADD, 32'd0, 4'd9, 32'd0, 4'd0, 32'h11, 4'd1);
        tick();
        disp(OP_ADD, 32'd0, 4'd9, 32'd0, 4'd0, 32'h22, 4'd2);
        tick();
        idle();
        cdb_alu_valid = 1'b1; cdb_alu_src = 4'd9; cdb_alu_val = 32'h90;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                cdb_alu_valid = 1'b0;
                disp(OP_ADDI, 32'd3, 4'd0, 32'd0, 4'd0, 32'h33, 4'd3);
            end
            tick();
            check($sformatf("stall_valid_%0d", i), 32'(rs_valid), 32'd0);
            check($sformatf("stall_count_%0d", i), 32'(dut.count), 32'd2);
        end
        idle();
        rdy = 1'b1;
        cdb_alu_valid = 1'b1; cdb_alu_src = 4'd9; cdb_alu_val = 32'h90;
        tick();
        idle();
        check("resume_wake_edge", 32'(rs_valid), 32'd0);
        tick();
        check("resume_a_valid", 32'(rs_valid), 32'd1);
        check("resume_a_imm", rs_imm, 32'h11);
        check("resume_a_val1", rs_val1, 32'h90);
        tick();
        check("resume_b_valid", 32'(rs_valid), 32'd1);
        check("resume_b_imm", rs_imm, 32'h22);
        tick();
        check("resume_done_valid", 32'(rs_valid), 32'd0);
        check("resume_done_count", 32'(dut.count), 32'd0);

        // Issued outputs hold while rdy is low.
        disp(OP_ADDI, 32'd8, 4'd0, 32'd0, 4'd0, 32'h44, 4'd6);
        tick();
        idle();
        tick();
        check("hold_pre_valid", 32'(rs_valid), 32'd1);
        rdy = 1'b0;
        tick();
        check("hold_valid", 32'(rs_valid), 32'd1);
        check("hold_imm", rs_imm, 32'h44);
        check("hold_rob", 32'(rs_rob_idx), 32'd6);
        rdy = 1'b1;
        tick();
        check("hold_release", 32'(rs_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
